// File: rtl/perf_pkg.sv
// Shared types and constants for the performance-counter bank.
package perf_pkg;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } state_e;

    // Read address that selects the cycle counter, one past the last event channel.
    function automatic int unsigned cyc_sel(input int unsigned num_ch);
        return num_ch;
    endfunction

endpackage

// File: rtl/perf_cnt_cell.sv
// Single event counter with wrap/saturate behaviour and a sticky overflow flag.
module perf_cnt_cell
    import perf_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic             sat_mode,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (inc) begin
            // An increment at all-ones flags overflow on the same edge it wraps or sticks.
            if (&cnt_q) begin
                ovf_d = 1'b1;
                if (!sat_mode) begin
                    cnt_d = '0;
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of NUM_CH event counters plus a cycle counter, with halt freeze and a registered read port.
module perf_counter_bank
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CH = 8,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = $clog2(NUM_CH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] event_in,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sat_mode,
    input  logic              halt,
    input  logic              clr,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [CNT_W-1:0]  rd_data,
    output logic              rd_valid,
    output logic [NUM_CH-1:0] ovf,
    output logic              cyc_ovf,
    output logic              frozen
);

    localparam int unsigned CYC_SEL = cyc_sel(NUM_CH);

    state_e           state_q;
    logic             frozen_q;
    logic [CNT_W-1:0] cnt [NUM_CH+1];
    logic [NUM_CH:0]  inc;
    logic [NUM_CH:0]  cell_ovf;
    logic [CNT_W-1:0] rd_mux;
    logic [CNT_W-1:0] rd_data_q;
    logic             rd_valid_q;

    // The halt cycle itself still counts; freezing takes effect from the next edge.
    always_comb begin
        inc = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            inc[i] = (state_q == RUN) & event_in[i] & ch_en[i];
        end
        inc[CYC_SEL] = (state_q == RUN);
    end

    for (genvar g = 0; g <= int'(NUM_CH); g++) begin : g_cell
        perf_cnt_cell #(
            .CNT_W(CNT_W)
        ) u_cell (
            .clk     (clk),
            .rst     (rst),
            .inc     (inc[g]),
            .clr     (clr),
            .sat_mode(sat_mode),
            .cnt     (cnt[g]),
            .ovf     (cell_ovf[g])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= RUN;
            frozen_q <= 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (!clr && halt) begin
                        state_q  <= FROZEN;
                        frozen_q <= 1'b1;
                    end
                end
                FROZEN: begin
                    if (clr) begin
                        state_q  <= RUN;
                        frozen_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= RUN;
                    frozen_q <= 1'b0;
                end
            endcase
        end
    end

    // Addresses beyond the cycle counter fall through to zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i <= int'(NUM_CH); i++) begin
            if (rd_addr == ADDR_W'(i)) begin
                rd_mux = cnt[i];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_mux;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign ovf      = cell_ovf[NUM_CH-1:0];
    assign cyc_ovf  = cell_ovf[CYC_SEL];
    assign frozen   = frozen_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Checks a 32-bit and a 4-bit counter bank, driven in lockstep, against a behavioural model.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  event_in, ch_en;
    logic        sat_mode, halt, clr, rd_req;
    logic [3:0]  rd_addr;

    logic [31:0] rd_data32;
    logic [3:0]  rd_data4;
    logic        rd_valid32, rd_valid4, cyc_ovf32, cyc_ovf4, frozen32, frozen4;
    logic [7:0]  ovf32, ovf4;

    int n_checks = 0;
    int n_errors = 0;

    // Model state: index 0 is the 32-bit bank, index 1 the 4-bit bank; counter 8 is the cycle count.
    int unsigned       wid [2] = '{32, 4};
    longint unsigned   m_cnt [2][9];
    bit                m_ovf [2][9];
    bit                m_frozen;
    longint unsigned   exp_rd [2];
    bit                exp_valid;

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CH(8), .CNT_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .event_in(event_in), .ch_en(ch_en), .sat_mode(sat_mode),
        .halt(halt), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data32),
        .rd_valid(rd_valid32), .ovf(ovf32), .cyc_ovf(cyc_ovf32), .frozen(frozen32)
    );

    perf_counter_bank #(.NUM_CH(8), .CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .event_in(event_in), .ch_en(ch_en), .sat_mode(sat_mode),
        .halt(halt), .clr(clr), .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data4),
        .rd_valid(rd_valid4), .ovf(ovf4), .cyc_ovf(cyc_ovf4), .frozen(frozen4)
    );

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int c = 0; c < 9; c++) begin
                m_cnt[k][c] = 0;
                m_ovf[k][c] = 1'b0;
            end
            exp_rd[k] = 0;
        end
        m_frozen  = 1'b0;
        exp_valid = 1'b0;
    endtask

    function automatic logic [7:0] exp_ovf(input int k);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = m_ovf[k][c];
        return v;
    endfunction

    // Advance model by one clock using current inputs, then step past the edge.
    task automatic tick();
        longint unsigned lim;
        bit due;
        exp_valid = rd_req;
        if (rd_req) begin
            for (int k = 0; k < 2; k++) exp_rd[k] = (rd_addr <= 8) ? m_cnt[k][rd_addr] : 0;
        end
        if (clr) begin
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 9; c++) begin
                    m_cnt[k][c] = 0;
                    m_ovf[k][c] = 1'b0;
                end
            m_frozen = 1'b0;
        end else if (!m_frozen) begin
            for (int c = 0; c < 9; c++) begin
                due = (c == 8) ? 1'b1 : (event_in[c] & ch_en[c]);
                if (due) begin
                    for (int k = 0; k < 2; k++) begin
                        lim = (64'd1 << wid[k]) - 1;
                        if (m_cnt[k][c] == lim) begin
                            m_ovf[k][c] = 1'b1;
                            m_cnt[k][c] = sat_mode ? lim : 0;
                        end else begin
                            m_cnt[k][c] = m_cnt[k][c] + 1;
                        end
                    end
                end
            end
            if (halt) m_frozen = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        event_in = '0;
        halt     = 1'b0;
        clr      = 1'b0;
        rd_req   = 1'b0;
        rd_addr  = '0;
    endtask

    task automatic do_clear();
        idle_inputs();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        ch_en    = 8'hFF;
        sat_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({rd_data32, rd_valid32, ovf32, cyc_ovf32, frozen32} !== '0) begin
            n_errors++;
            $display("FAIL reset32: got data=%0h valid=%b ovf=%h cyc_ovf=%b frozen=%b, want all 0",
                     rd_data32, rd_valid32, ovf32, cyc_ovf32, frozen32);
        end
        n_checks++;
        if ({rd_data4, rd_valid4, ovf4, cyc_ovf4, frozen4} !== '0) begin
            n_errors++;
            $display("FAIL reset4: got data=%0h valid=%b ovf=%h cyc_ovf=%b frozen=%b, want all 0",
                     rd_data4, rd_valid4, ovf4, cyc_ovf4, frozen4);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_reads();
        int unsigned addrs [4] = '{0, 1, 2, 8};
        int unsigned want32 [4] = '{10, 0, 10, 13};
        event_in = 8'h05;
        repeat (10) tick();
        event_in = 8'h00;
        for (int i = 0; i < 4; i++) begin
            rd_req  = 1'b1;
            rd_addr = 4'(addrs[i]);
            tick();
            n_checks++;
            if (rd_valid32 !== 1'b1 || rd_data32 !== want32[i]) begin
                n_errors++;
                $display("FAIL basic_read32 addr=%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         addrs[i], rd_valid32, rd_data32, want32[i]);
            end
            n_checks++;
            if (rd_valid4 !== 1'b1 || rd_data4 !== 4'(exp_rd[1])) begin
                n_errors++;
                $display("FAIL basic_read4 addr=%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         addrs[i], rd_valid4, rd_data4, exp_rd[1]);
            end
        end
        rd_req = 1'b0;
        tick();
        n_checks++;
        if (rd_valid32 !== 1'b0 || rd_data32 !== 32'd13) begin
            n_errors++;
            $display("FAIL read_hold: got valid=%b data=%0d, want valid=0 data=13",
                     rd_valid32, rd_data32);
        end
    endtask

    task automatic test_wrap();
        do_clear();
        sat_mode = 1'b0;
        event_in = 8'h01;
        for (int i = 1; i <= 17; i++) begin
            tick();
            n_checks++;
            if (ovf4[0] !== (i >= 16)) begin
                n_errors++;
                $display("FAIL wrap_ovf event=%0d: got ovf4[0]=%b, want %b", i, ovf4[0], i >= 16);
            end
        end
        event_in = 8'h00;
        rd_req   = 1'b1;
        rd_addr  = 4'd0;
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_data4 !== 4'd1 || rd_data32 !== 32'd17) begin
            n_errors++;
            $display("FAIL wrap_read: got ch0 4b=%0d 32b=%0d, want 1 and 17", rd_data4, rd_data32);
        end
    endtask

    task automatic test_sat();
        do_clear();
        sat_mode = 1'b1;
        event_in = 8'h08;
        repeat (20) tick();
        event_in = 8'h00;
        rd_req   = 1'b1;
        rd_addr  = 4'd3;
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_data4 !== 4'd15 || rd_data32 !== 32'd20) begin
            n_errors++;
            $display("FAIL sat_read: got ch3 4b=%0d 32b=%0d, want 15 and 20", rd_data4, rd_data32);
        end
        n_checks++;
        if (ovf4 !== 8'h08 || ovf32 !== 8'h00 || cyc_ovf4 !== 1'b1 || cyc_ovf32 !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_ovf: got ovf4=%h ovf32=%h cyc4=%b cyc32=%b, want 08 00 1 0",
                     ovf4, ovf32, cyc_ovf4, cyc_ovf32);
        end
        sat_mode = 1'b0;
    endtask

    task automatic test_halt();
        do_clear();
        event_in = 8'h02;
        repeat (4) tick();
        halt = 1'b1;
        tick();
        halt = 1'b0;
        n_checks++;
        if (frozen32 !== 1'b1 || frozen4 !== 1'b1) begin
            n_errors++;
            $display("FAIL halt_frozen: got frozen32=%b frozen4=%b, want 1 1", frozen32, frozen4);
        end
        event_in = 8'hFF;
        halt     = 1'b1;
        repeat (20) tick();
        halt    = 1'b0;
        rd_req  = 1'b1;
        rd_addr = 4'd1;
        tick();
        n_checks++;
        if (rd_data32 !== 32'd5) begin
            n_errors++;
            $display("FAIL halt_ch1: got %0d, want 5", rd_data32);
        end
        rd_addr = 4'd8;
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_data32 !== 32'd5 || rd_data4 !== 4'(exp_rd[1])) begin
            n_errors++;
            $display("FAIL halt_cyc: got 32b=%0d 4b=%0d, want 5 and %0d",
                     rd_data32, rd_data4, exp_rd[1]);
        end
        event_in = 8'h00;
    endtask

    task automatic test_clr_read();
        clr     = 1'b1;
        rd_req  = 1'b1;
        rd_addr = 4'd1;
        tick();
        clr    = 1'b0;
        rd_req = 1'b0;
        n_checks++;
        if (rd_data32 !== 32'd5 || rd_valid32 !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_read: got data=%0d valid=%b, want 5 1", rd_data32, rd_valid32);
        end
        n_checks++;
        if (frozen32 !== 1'b0 || ovf32 !== 8'h00 || ovf4 !== 8'h00 || cyc_ovf4 !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_state: got frozen=%b ovf32=%h ovf4=%h cyc4=%b, want 0 00 00 0",
                     frozen32, ovf32, ovf4, cyc_ovf4);
        end
        event_in = 8'h02;
        tick();
        event_in = 8'h00;
        rd_req   = 1'b1;
        rd_addr  = 4'd1;
        tick();
        rd_addr = 4'd8;
        n_checks++;
        if (rd_data32 !== 32'd1) begin
            n_errors++;
            $display("FAIL clr_resume_ch1: got %0d, want 1", rd_data32);
        end
        tick();
        rd_req = 1'b0;
        n_checks++;
        if (rd_data32 !== 32'd2) begin
            n_errors++;
            $display("FAIL clr_resume_cyc: got %0d, want 2", rd_data32);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            event_in = 8'($urandom);
            ch_en    = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            if ($urandom_range(0, 15) == 0) sat_mode = ~sat_mode;
            halt     = ($urandom_range(0, 39) == 0);
            clr      = ($urandom_range(0, 59) == 0);
            rd_req   = 1'($urandom);
            rd_addr  = 4'($urandom);
            tick();
            n_checks++;
            if (rd_valid32 !== exp_valid || rd_data32 !== 32'(exp_rd[0]) ||
                rd_valid4 !== exp_valid || rd_data4 !== 4'(exp_rd[1])) begin
                n_errors++;
                $display("FAIL rand_read cyc=%0d: got v=%b/%b d=%0h/%0h, want v=%b d=%0h/%0h",
                         i, rd_valid32, rd_valid4, rd_data32, rd_data4, exp_valid,
                         exp_rd[0], exp_rd[1]);
            end
            n_checks++;
            if (ovf32 !== exp_ovf(0) || ovf4 !== exp_ovf(1) || cyc_ovf32 !== m_ovf[0][8] ||
                cyc_ovf4 !== m_ovf[1][8] || frozen32 !== m_frozen || frozen4 !== m_frozen) begin
                n_errors++;
                $display("FAIL rand_flags cyc=%0d: got ovf=%h/%h cyc=%b/%b fz=%b/%b, want %h/%h %b/%b %b",
                         i, ovf32, ovf4, cyc_ovf32, cyc_ovf4, frozen32, frozen4,
                         exp_ovf(0), exp_ovf(1), m_ovf[0][8], m_ovf[1][8], m_frozen);
            end
        end
        idle_inputs();
        ch_en    = 8'hFF;
        sat_mode = 1'b0;
    endtask

    task automatic test_async_reset();
        event_in = 8'h0F;
        repeat (3) tick();
        event_in = 8'h00;
        rd_req   = 1'b1;
        rd_addr  = 4'd0;
        #2 rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        n_checks++;
        if (rd_valid32 !== 1'b0 || rd_valid4 !== 1'b0 || rd_data32 !== 32'd0) begin
            n_errors++;
            $display("FAIL async_rst_valid: got valid=%b/%b data=%0d, want 0/0 0",
                     rd_valid32, rd_valid4, rd_data32);
        end
        rst = 1'b0;
        for (int a = 0; a <= 9; a++) begin
            rd_req  = 1'b1;
            rd_addr = 4'(a);
            tick();
            n_checks++;
            if (rd_valid32 !== 1'b1 || rd_data32 !== 32'(exp_rd[0]) ||
                (a < 8 && rd_data32 !== 32'd0) || (a == 9 && rd_data32 !== 32'd0)) begin
                n_errors++;
                $display("FAIL post_rst_read addr=%0d: got valid=%b data=%0d, want valid=1 data=%0d",
                         a, rd_valid32, rd_data32, exp_rd[0]);
            end
        end
        rd_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_reads();
        test_wrap();
        test_sat();
        test_halt();
        test_clr_read();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
